// File: rtl/chip8_pkg.sv
// Shared CHIP-8 types and widths: the random-unit state enum plus the register
// index and byte widths used by the CPU and the V-register file.
package chip8_pkg;

    localparam int VREG_IDX_W = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        RAND_IDLE   = 2'd0,
        RAND_SAMPLE = 2'd1,
        RAND_WRITE  = 2'd2
    } rand_state_t;

endpackage

// File: rtl/chip8_rand_unit_if.sv
// CXNN request handshake plus the V-register write port, grouped for the CPU
// (master) and the random unit (slave).
interface chip8_rand_unit_if;
    import chip8_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [VREG_IDX_W-1:0] req_x;
    logic [BYTE_W-1:0]     req_nn;
    logic                  wr_en;
    logic [VREG_IDX_W-1:0] wr_addr;
    logic [BYTE_W-1:0]     wr_data;
    logic                  done;

    modport master (
        output req_valid, req_x, req_nn,
        input  req_ready, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  req_valid, req_x, req_nn,
        output req_ready, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/chip8_edge_rise.sv
// Single-bit rising-edge detector: one-cycle pulse in the cycle after a 0->1
// transition of din. Also used by the keypad wait instruction.
module chip8_edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic prev_reg;
    logic pulse_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            prev_reg  <= din;
            pulse_reg <= din & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/chip8_rand_unit.sv
// CHIP-8 CXNN executor: samples the rng byte, masks it with NN and writes VX.
// Define CHIP8_RNG_STIR_EN to turn keypad presses into rng stir pulses.
module chip8_rand_unit
    import chip8_pkg::*;
#(
    parameter int MIN_GAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    chip8_rand_unit_if.slave   bus,
    input  logic [BYTE_W-1:0]  rng_byte,
    output logic               rng_stir,
    input  logic               key_down
);

    localparam logic [3:0] GAP = 4'(MIN_GAP);

    rand_state_t           state_reg, state_next;
    logic [VREG_IDX_W-1:0] x_reg;
    logic [BYTE_W-1:0]     nn_reg;
    logic [3:0]            gap_reg;
    logic [VREG_IDX_W-1:0] addr_reg;
    logic [BYTE_W-1:0]     data_reg;
    logic                  accept;
    logic                  sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RAND_IDLE;
            x_reg     <= '0;
            nn_reg    <= '0;
            gap_reg   <= GAP;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                x_reg  <= bus.req_x;
                nn_reg <= bus.req_nn;
            end
            // Output registers load only on a sample so they hold between writes.
            if (sample) begin
                data_reg <= rng_byte & nn_reg;
                addr_reg <= x_reg;
                gap_reg  <= '0;
            end else if (gap_reg < GAP) begin
                gap_reg <= gap_reg + 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state_reg)
            RAND_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = RAND_SAMPLE;
                end
            end
            RAND_SAMPLE: begin
                if (gap_reg >= GAP) begin
                    sample     = 1'b1;
                    state_next = RAND_WRITE;
                end
            end
            RAND_WRITE: state_next = RAND_IDLE;
            default:    state_next = RAND_IDLE;
        endcase
    end

    // Gated by rst so nothing handshakes or writes while reset is held.
    assign bus.req_ready = (state_reg == RAND_IDLE)  && !rst;
    assign bus.wr_en     = (state_reg == RAND_WRITE) && !rst;
    assign bus.done      = (state_reg == RAND_WRITE) && !rst;
    assign bus.wr_addr   = addr_reg;
    assign bus.wr_data   = data_reg;

`ifdef CHIP8_RNG_STIR_EN
    chip8_edge_rise u_stir (
        .clk   (clk),
        .rst   (rst),
        .din   (key_down),
        .pulse (rng_stir)
    );
`else
    logic key_unused;
    assign key_unused = key_down;
    assign rng_stir   = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_rand_unit.sv
// Directed bench for chip8_rand_unit: a MIN_GAP=1 instance for the main paths
// and a MIN_GAP=6 instance for the sample-gap stall.
module tb_chip8_rand_unit;
    import chip8_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rng_byte;
    logic [7:0] rng_g6;
    logic       key_down;
    logic       stir;
    logic       stir_g6;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] byte_at(input int c);
        return 8'(c * 29 + 17);
    endfunction

    // Second instance sees a byte that changes every cycle.
    assign rng_g6 = byte_at(cyc);

    chip8_rand_unit_if bus();
    chip8_rand_unit_if bus_g6();

    chip8_rand_unit #(.MIN_GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rng_byte (rng_byte),
        .rng_stir (stir),
        .key_down (key_down)
    );

    chip8_rand_unit #(.MIN_GAP(6)) dut_g6 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_g6.slave),
        .rng_byte (rng_g6),
        .rng_stir (stir_g6),
        .key_down (1'b0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // One request on the MIN_GAP=1 instance with fixed 0/1/2/3 cycle timing.
    task automatic issue(input logic [3:0] x, input logic [7:0] nn, input logic [7:0] rb,
                         input logic [7:0] exp, input string tag);
        wait_ready(tag);
        rng_byte      = rb;
        bus.req_valid = 1'b1;
        bus.req_x     = x;
        bus.req_nn    = nn;
        tick();
        bus.req_valid = 1'b0;
        check_val({tag, " c1 wr_en"}, 32'(bus.wr_en), 32'd0);
        tick();
        check_val({tag, " c2 wr_en"}, 32'(bus.wr_en), 32'd1);
        check_val({tag, " c2 done"}, 32'(bus.done), 32'd1);
        check_val({tag, " c2 wr_addr"}, 32'(bus.wr_addr), 32'(x));
        check_val({tag, " c2 wr_data"}, 32'(bus.wr_data), 32'(exp));
        $display("txn %s x=%0d nn=%02h rng=%02h wr_data=%02h", tag, x, nn, rb, bus.wr_data);
        tick();
        check_val({tag, " c3 ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, " c3 done"}, 32'(bus.done), 32'd0);
        check_val({tag, " c3 hold data"}, 32'(bus.wr_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs, wr, w1, w2, a, w_at, k0, pulses, p_at;
        logic [7:0] d_at;
        logic [3:0] x_at;

        rng_byte         = 8'h00;
        key_down         = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_x        = '0;
        bus.req_nn       = '0;
        bus_g6.req_valid = 1'b0;
        bus_g6.req_x     = '0;
        bus_g6.req_nn    = '0;

        // Reset values while rst is held
        repeat (3) tick();
        check_val("rst ready", 32'(bus.req_ready), 32'd0);
        check_val("rst wr_en", 32'(bus.wr_en), 32'd0);
        check_val("rst done", 32'(bus.done), 32'd0);
        check_val("rst wr_addr", 32'(bus.wr_addr), 32'd0);
        check_val("rst wr_data", 32'(bus.wr_data), 32'd0);
        check_val("rst stir", 32'(stir), 32'd0);
        rst = 1'b0;
        tick();
        check_val("post-rst ready", 32'(bus.req_ready), 32'd1);

        // Basic write and mask edges
        issue(4'd3,  8'h0F, 8'hA7, 8'h07, "basic");
        issue(4'd5,  8'h00, 8'hA7, 8'h00, "mask00");
        issue(4'd15, 8'hFF, 8'h5C, 8'h5C, "maskFF");
        issue(4'd0,  8'hF0, 8'h3C, 8'h30, "maskF0");

        // Request held high: handshakes at 0,3,6 and writes at 2,5,8
        wait_ready("hold");
        hs = 0; wr = 0; w1 = -1; w2 = -1;
        rng_byte      = 8'h6E;
        bus.req_valid = 1'b1;
        bus.req_x     = 4'd7;
        bus.req_nn    = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            if (i == 7) bus.req_valid = 1'b0;
            if (bus.req_valid && bus.req_ready) hs++;
            if (bus.wr_en) begin
                wr++;
                if (w1 < 0) w1 = i;
                else if (w2 < 0) w2 = i;
            end
            tick();
        end
        $display("txn hold handshakes=%0d writes=%0d", hs, wr);
        check_val("hold handshakes", 32'(hs), 32'd3);
        check_val("hold writes", 32'(wr), 32'd3);
        check_val("hold first write", 32'(w1), 32'd2);
        check_val("hold second write", 32'(w2), 32'd5);

        // Reset asserted during SAMPLE
        wait_ready("rstmid");
        rng_byte      = 8'h99;
        bus.req_valid = 1'b1;
        bus.req_x     = 4'd4;
        bus.req_nn    = 8'hFF;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        check_val("rstmid ready in rst", 32'(bus.req_ready), 32'd0);
        tick();
        check_val("rstmid wr_en", 32'(bus.wr_en), 32'd0);
        check_val("rstmid done", 32'(bus.done), 32'd0);
        check_val("rstmid wr_data", 32'(bus.wr_data), 32'd0);
        rst = 1'b0;
        tick();
        check_val("rstmid ready after", 32'(bus.req_ready), 32'd1);
        check_val("rstmid no write", 32'(bus.wr_en), 32'd0);
        $display("txn rstmid aborted x=4");
        issue(4'd6, 8'h81, 8'hC3, 8'h81, "after-rst");

        // Gap stall on MIN_GAP=6: samples at A+1 and A+8
        a = cyc;
        bus_g6.req_valid = 1'b1;
        bus_g6.req_x     = 4'd2;
        bus_g6.req_nn    = 8'hFF;
        check_val("g6 ready", 32'(bus_g6.req_ready), 32'd1);
        tick();
        tick();
        check_val("g6 w1 wr_en", 32'(bus_g6.wr_en), 32'd1);
        check_val("g6 w1 wr_data", 32'(bus_g6.wr_data), 32'(byte_at(a + 1)));
        $display("txn g6 first x=2 wr_data=%02h", bus_g6.wr_data);
        bus_g6.req_x  = 4'd9;
        bus_g6.req_nn = 8'h3C;
        tick();
        check_val("g6 ready again", 32'(bus_g6.req_ready), 32'd1);
        tick();
        bus_g6.req_valid = 1'b0;
        w_at = -1; d_at = '0; x_at = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus_g6.wr_en && w_at < 0) begin
                w_at = cyc - a;
                d_at = bus_g6.wr_data;
                x_at = bus_g6.wr_addr;
            end
            tick();
        end
        $display("txn g6 second x=%0d wr_data=%02h at A+%0d", x_at, d_at, w_at);
        check_val("g6 w2 cycle", 32'(w_at), 32'd9);
        check_val("g6 w2 wr_addr", 32'(x_at), 32'd9);
        check_val("g6 w2 wr_data", 32'(d_at), 32'(byte_at(a + 8) & 8'h3C));

        // Keypad stir: key held for 10 cycles
        tick();
        tick();
        key_down = 1'b1;
        k0 = cyc;
        pulses = 0; p_at = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (stir) begin
                pulses++;
                if (p_at < 0) p_at = cyc - k0;
            end
            if (i == 9) key_down = 1'b0;
        end
        $display("txn stir pulses=%0d first_at=%0d", pulses, p_at);
`ifdef CHIP8_RNG_STIR_EN
        check_val("stir pulses", 32'(pulses), 32'd1);
        check_val("stir timing", 32'(p_at), 32'd1);
`else
        check_val("stir pulses", 32'(pulses), 32'd0);
        check_val("stir timing", 32'(p_at), 32'hFFFF_FFFF);
`endif
        check_val("g6 stir idle", 32'(stir_g6), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
